// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial-adder scheduler: frame width, requester count, sequencer states.
package serial_add_pkg;

    localparam int unsigned SADD_W    = 4;
    localparam int unsigned SADD_NREQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIT0  = 3'd1,
        ST_BIT1  = 3'd2,
        ST_BIT2  = 3'd3,
        ST_BIT3  = 3'd4,
        ST_FLUSH = 3'd5,
        ST_OVF   = 3'd6,
        ST_RESP  = 3'd7
    } sadd_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, priority pointer advances on every grant.
module rr_arb2
    import serial_add_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [SADD_NREQ-1:0] req_i,
    output logic [SADD_NREQ-1:0] gnt_o
);

    // prio_q names the requester that wins when both are valid
    logic prio_q, prio_d;

    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
                default: gnt_o = '0;
            endcase
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt_o[0]) prio_d = 1'b1;
        if (gnt_o[1]) prio_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) prio_q <= 1'b0;
        else       prio_q <= prio_d;
    end

endmodule

// File: rtl/serial_add_sched.sv
// Arbitrates two requesters onto the shared 4-bit serial adder, serializes operands LSB-first and
// reassembles the sum. Optional parallel self-check enabled by defining SADD_SELFCHECK_EN.
module serial_add_sched
    import serial_add_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [SADD_NREQ-1:0]   req_valid,
    input  logic [2*SADD_W-1:0]    req_a,
    input  logic [2*SADD_W-1:0]    req_b,
    output logic [SADD_NREQ-1:0]   req_grant,
    output logic                   busy,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic [SADD_W-1:0]      rsp_sum,
    output logic                   rsp_ovf,
    output logic                   rsp_err,
    output logic                   add_reset,
    output logic                   add_line1,
    output logic                   add_line2,
    input  logic                   add_outp,
    input  logic                   add_ovf
);

    sadd_state_e state_q, state_d;

    logic [SADD_NREQ-1:0] gnt;
    logic                 can_grant, granted;
    logic [SADD_W-1:0]    sel_a, sel_b;

    logic [SADD_W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d, rsp_sum_q, rsp_sum_d;
    logic                 id_q, id_d, rsp_id_q, rsp_id_d, rsp_ovf_q, rsp_ovf_d;
    logic                 rsp_valid_q, rsp_valid_d, busy_q, busy_d;
    logic                 add_reset_q, add_reset_d, line1_q, line1_d, line2_q, line2_d;
    logic [SADD_NREQ-1:0] grant_q;

    assign can_grant = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign granted   = |gnt;
    assign sel_a     = gnt[1] ? req_a[2*SADD_W-1:SADD_W] : req_a[SADD_W-1:0];
    assign sel_b     = gnt[1] ? req_b[2*SADD_W-1:SADD_W] : req_b[SADD_W-1:0];

    rr_arb2 u_arb (
        .clk_i (clock),
        .rst_i (reset),
        .en_i  (can_grant),
        .req_i (req_valid),
        .gnt_o (gnt)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (granted) state_d = ST_BIT0;
            ST_BIT0:  state_d = ST_BIT1;
            ST_BIT1:  state_d = ST_BIT2;
            ST_BIT2:  state_d = ST_BIT3;
            ST_BIT3:  state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_OVF;
            ST_OVF:   state_d = ST_RESP;
            ST_RESP:  state_d = granted ? ST_BIT0 : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef SADD_SELFCHECK_EN
    logic [SADD_W:0] ref_q, ref_d;
    logic            err_q, err_d;
`endif

    // Lines are driven from the next state so the first bit leaves on the grant edge itself.
    always_comb begin
        a_d         = granted ? sel_a : a_q;
        b_d         = granted ? sel_b : b_q;
        id_d        = granted ? gnt[1] : id_q;
        sum_d       = sum_q;
        rsp_valid_d = (state_q == ST_OVF);
        rsp_sum_d   = rsp_valid_d ? sum_q : rsp_sum_q;
        rsp_ovf_d   = rsp_valid_d ? add_ovf : rsp_ovf_q;
        rsp_id_d    = rsp_valid_d ? id_q : rsp_id_q;
        unique case (state_q)
            ST_BIT1:  sum_d[0] = add_outp;
            ST_BIT2:  sum_d[1] = add_outp;
            ST_BIT3:  sum_d[2] = add_outp;
            ST_FLUSH: sum_d[3] = add_outp;
            default:  ;
        endcase
        line1_d     = 1'b0;
        line2_d     = 1'b0;
        add_reset_d = 1'b0;
        unique case (state_d)
            ST_BIT0:  begin line1_d = a_d[0]; line2_d = b_d[0]; end
            ST_BIT1:  begin line1_d = a_d[1]; line2_d = b_d[1]; end
            ST_BIT2:  begin line1_d = a_d[2]; line2_d = b_d[2]; end
            ST_BIT3:  begin line1_d = a_d[3]; line2_d = b_d[3]; end
            ST_FLUSH: ;
            default:  add_reset_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
`ifdef SADD_SELFCHECK_EN
        ref_d = granted ? ({1'b0, sel_a} + {1'b0, sel_b}) : ref_q;
        err_d = rsp_valid_d && ({add_ovf, sum_q} != ref_q);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            sum_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_id_q    <= 1'b0;
            line1_q     <= 1'b0;
            line2_q     <= 1'b0;
            add_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            grant_q     <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            sum_q       <= sum_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_id_q    <= rsp_id_d;
            line1_q     <= line1_d;
            line2_q     <= line2_d;
            add_reset_q <= add_reset_d;
            busy_q      <= busy_d;
            grant_q     <= gnt;
        end
    end

`ifdef SADD_SELFCHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            ref_q <= '0;
            err_q <= 1'b0;
        end else begin
            ref_q <= ref_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && err_q)
            $error("serial_add_sched: serial result %0h differs from reference %0h",
                   {rsp_ovf_q, rsp_sum_q}, ref_q);
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req_grant = grant_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign add_reset = add_reset_q;
    assign add_line1 = line1_q;
    assign add_line2 = line2_q;

endmodule
